cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Parametrised commit-trace capture buffer for the MIPS CPU. It sits beside `top` and samples the per-instruction retire bundle: PC, instruction word and register write-back. It stores the bundle in a circular buffer in one of two modes, fill-once or wrap-until-trigger. After capture it drains oldest-first over a valid/ready port to a debug host or a simulation checker.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, ≥ 4.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width.
- `POST_TRIG`, `DEPTH/2`: entries captured after the trigger entry in WRAP mode; range 0..DEPTH-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `arm` in 1: one-cycle pulse that starts a capture; honoured only in IDLE.
- `mode` in 1: 0 = FILL, 1 = WRAP. Sampled when `arm` is honoured.
- `trig_pc` in 32: trigger PC for WRAP mode. Sampled when `arm` is honoured.
- `cap_en` in 1: a valid retire bundle is present this cycle.
- `pc` in 32: PC of the retiring instruction.
- `instruction` in 32: instruction word.
- `RegWrite` in 1: write-back enable.
- `r3_addr_mux` in 5: write-back register address.
- `reg_datain` in 32: write-back data.
- `rd_valid` out 1: an entry is presented on the `rd_*` outputs.
- `rd_ready` in 1: host accepts the presented entry.
- `rd_pc`, `rd_instr`, `rd_wdata` out 32 each; `rd_we` out 1; `rd_waddr` out 5: the presented entry.
- `count` out ADDR_W+1: number of entries currently held.
- `triggered` out 1: the trigger has matched during this capture.
- `done` out 1: capture has ended and the buffer is draining.

## Operation
- Entry: {pc, instruction, RegWrite, r3_addr_mux, reg_datain}, 102 bits.
- States:
  - IDLE: `arm` → ARMED. Clears `wr_ptr`, `count` and `triggered`, and latches `mode` and `trig_pc`.
  - ARMED: each `cap_en` cycle writes `mem[wr_ptr]`, increments `wr_ptr` (wraps mod DEPTH) and increments `count`, which saturates at DEPTH.
    - FILL mode: the write that makes `count` equal DEPTH → DRAIN. Further samples are never written.
    - WRAP mode: a sample with `pc == trig_pc` is written and sets `triggered`, loads `post_cnt = POST_TRIG` → POST. If POST_TRIG = 0 the next state is DRAIN directly.
  - POST: each `cap_en` write decrements `post_cnt`; the write that takes it to 0 → DRAIN. Trigger matches in POST are ignored.
  - DRAIN: `done` = 1 and `rd_ptr` = `wr_ptr - count` (mod DEPTH).
    - `rd_valid` = (count ≠ 0). The `rd_*` outputs are combinational from `mem[rd_ptr]`.
    - On `rd_valid && rd_ready`: `rd_ptr`++ (wrap) and `count`--.
    - The handshake that takes `count` to 0 → IDLE.
    - An `arm` pulse in DRAIN is ignored; the drain always completes.
- Buffer overwrite in WRAP mode: once full, new writes overwrite the oldest entry and `count` stays at DEPTH, so the oldest entry is lost.
- `arm` in any state other than IDLE is ignored.
- `cap_en` is ignored in IDLE and DRAIN.

## Timing
- Reset values: state IDLE; all pointers, `count` and `post_cnt` = 0; `triggered` = 0, `done` = 0, `rd_valid` = 0. The `rd_*` data outputs are don't-care while `rd_valid` = 0.
- Reset mid-capture or mid-drain aborts immediately to IDLE. No entry is retained.
- Sampling:
  - The first sample that can be captured is the cycle after the `arm` cycle.
  - The bundle is written at the rising edge of the `cap_en` cycle.
  - `count` reflects that write in the following cycle.
- The cycle after the final capture write: `done` = 1 and `rd_valid` = 1.
- Read handshake:
  - Zero-latency: the entry is visible in the same cycle `rd_valid` rises.
  - With `rd_ready` held high, one entry drains per cycle.
  - If `rd_ready` is low, the `rd_*` outputs hold stable.
- Full-rate drain time: DEPTH cycles. IDLE is entered the cycle after the last handshake.
- Trigger comparison is a full 32-bit equality.
- `count` never exceeds DEPTH. `post_cnt` is ADDR_W bits wide.

## Structure
- The shared package `cpu_dbg_pkg` holds:
  - the state enum `trace_state_t` (IDLE, ARMED, POST, DRAIN);
  - the `trace_entry_t` struct for the entry bundle;
  - the mode constants `TRACE_FILL` = 0 and `TRACE_WRAP` = 1.
- Sub-module `trace_ram`: DEPTH × 102 storage with a synchronous write port and an asynchronous read port, and no reset on the array.
- The top level instantiates this block in parallel with the CPU and wires the CPU debug outputs to its capture inputs.

## Test plan
- FILL, DEPTH = 16: arm, then 20 consecutive `cap_en` cycles with pc = 0x00, 0x04, … 0x4C.
  - Required: `done` after the 16th write; `count` = 16.
  - With `rd_ready` = 1, the drain returns pc 0x00..0x3C in order, then IDLE.
- WRAP, trig_pc = 0x80, POST_TRIG = 4: pc from 0x00 step 4 up to 0x94.
  - Required: `triggered` is set on 0x80, capture stops after 0x90, and `count` = 16.
  - Drain returns pc 0x54..0x90 in order.
- WRAP, POST_TRIG = 0, trigger on the 3rd sample.
  - Required: `count` = 3 and the drain returns exactly those 3 entries.
- Drain backpressure: toggle `rd_ready` 1,0,0,1 while draining.
  - Required: `rd_*` stable while ready is low, no entry lost or duplicated, and `count` decrements only on handshakes.
- `rst_n` pulsed low during POST and during DRAIN.
  - Required: state returns to IDLE asynchronously, all outputs take their reset values, and a new `arm` works normally.
- `arm` pulses during ARMED and DRAIN, and `cap_en` activity in IDLE and DRAIN.
  - Required: all of them are ignored and `count` is unchanged.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared debug types for the commit-trace buffer.
// Entry bundle, capture FSM states and mode codes.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DRAIN
  } trace_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_entry_t;

  localparam logic TRACE_FILL = 1'b0;
  localparam logic TRACE_WRAP = 1'b1;

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Read-out port of the trace buffer.
// Valid/ready handshake carrying one retired entry.
interface trace_rd_if;

  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;

  modport master (
    output rd_valid,
    output rd_pc,
    output rd_instr,
    output rd_we,
    output rd_waddr,
    output rd_wdata,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_pc,
    input  rd_instr,
    input  rd_we,
    input  rd_waddr,
    input  rd_wdata,
    output rd_ready
  );

endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: sync write, async read.
// The array is not reset; validity is tracked by count.
module trace_ram
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  trace_entry_t      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output trace_entry_t      rdata_o
);

  trace_entry_t mem_q [DEPTH];

  // Write the retire bundle on the capture edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture buffer (FILL / WRAP modes).
// Captures retire bundles, then drains oldest-first.
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int POST_TRIG = DEPTH / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              mode,
  input  logic [31:0]       trig_pc,
  input  logic              cap_en,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  input  logic              RegWrite,
  input  logic [4:0]        r3_addr_mux,
  input  logic [31:0]       reg_datain,
  trace_rd_if.master        rd,
  output logic [ADDR_W:0]   count,
  output logic              triggered,
  output logic              done
);

  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PT   = ADDR_W'(POST_TRIG);

  trace_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic              trig_q, trig_d;
  logic              mode_q, mode_d;
  logic [31:0]       trig_pc_q, trig_pc_d;
  logic              we;
  logic [ADDR_W-1:0] rd_ptr;
  trace_entry_t      wentry;
  trace_entry_t      rentry;

  assign wentry = '{pc: pc, instr: instruction, we: RegWrite,
                    waddr: r3_addr_mux, wdata: reg_datain};

  // Oldest held entry sits count slots behind the write pointer.
  assign rd_ptr = wr_ptr_q - count_q[ADDR_W-1:0];

  trace_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wentry),
    .raddr_i (rd_ptr),
    .rdata_o (rentry)
  );

  // Capture/drain state and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_q     <= 1'b0;
      mode_q     <= TRACE_FILL;
      trig_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_q     <= trig_d;
      mode_q     <= mode_d;
      trig_pc_q  <= trig_pc_d;
    end
  end

  // Next-state: arm, capture, post-trigger countdown, drain.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_d     = trig_q;
    mode_d     = mode_q;
    trig_pc_d  = trig_pc_q;
    we         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = ARMED;
          wr_ptr_d  = '0;
          count_d   = '0;
          trig_d    = 1'b0;
          mode_d    = mode;
          trig_pc_d = trig_pc;
        end
      end
      ARMED: begin
        if (cap_en) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != FULL) count_d = count_q + 1'b1;
          if (mode_q == TRACE_FILL) begin
            if (count_q == FULL - 1'b1) state_d = DRAIN;
          end else if (pc == trig_pc_q) begin
            trig_d     = 1'b1;
            post_cnt_d = PT;
            state_d    = (POST_TRIG == 0) ? DRAIN : POST;
          end
        end
      end
      POST: begin
        if (cap_en) begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (count_q != FULL) count_d = count_q + 1'b1;
          if (post_cnt_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = IDLE;
        end else if (rd.rd_ready) begin
          count_d = count_q - 1'b1;
          if (count_q == (ADDR_W + 1)'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done        = (state_q == DRAIN);
  assign rd.rd_valid = done && (count_q != '0);
  assign rd.rd_pc    = rentry.pc;
  assign rd.rd_instr = rentry.instr;
  assign rd.rd_we    = rentry.we;
  assign rd.rd_waddr = rentry.waddr;
  assign rd.rd_wdata = rentry.wdata;
  assign count       = count_q;
  assign triggered   = trig_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer.
// Two instances: POST_TRIG = 4 and POST_TRIG = 0.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm0 = 1'b0;
  logic        arm1 = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        cap_en = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instruction = '0;
  logic        RegWrite = 1'b0;
  logic [4:0]  r3_addr_mux = '0;
  logic [31:0] reg_datain = '0;
  logic [4:0]  count0, count1;
  logic        trig0, trig1, done0, done1;

  int n_pass = 0;
  int n_total = 0;

  trace_rd_if rd0 ();
  trace_rd_if rd1 ();

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(16), .POST_TRIG(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm0), .mode(mode),
    .trig_pc(trig_pc), .cap_en(cap_en), .pc(pc),
    .instruction(instruction), .RegWrite(RegWrite),
    .r3_addr_mux(r3_addr_mux), .reg_datain(reg_datain),
    .rd(rd0), .count(count0), .triggered(trig0), .done(done0)
  );

  cpu_trace_buffer #(.DEPTH(16), .POST_TRIG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm1), .mode(mode),
    .trig_pc(trig_pc), .cap_en(cap_en), .pc(pc),
    .instruction(instruction), .RegWrite(RegWrite),
    .r3_addr_mux(r3_addr_mux), .reg_datain(reg_datain),
    .rd(rd1), .count(count1), .triggered(trig1), .done(done1)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] p);
    return p + 32'h0000_0100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cap(input logic [31:0] p);
    logic [31:0] v;
    v = p;
    cap_en = 1'b1;
    pc = v;
    instruction = instr_of(v);
    RegWrite = v[2];
    r3_addr_mux = v[6:2];
    reg_datain = wdata_of(v);
    @(negedge clk);
    cap_en = 1'b0;
  endtask

  task automatic pulse_arm0(input logic m, input logic [31:0] t);
    mode = m;
    trig_pc = t;
    arm0 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0;
  endtask

  task automatic drain0(input logic [31:0] base, input int n,
                        input bit bp);
    int k;
    int cyc;
    logic [31:0] e;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      e = base + 32'(4 * k);
      chk("d0_valid", rd0.rd_valid, 1);
      chk("d0_pc", rd0.rd_pc, e);
      chk("d0_instr", rd0.rd_instr, instr_of(e));
      chk("d0_we", rd0.rd_we, e[2]);
      chk("d0_waddr", rd0.rd_waddr, e[6:2]);
      chk("d0_wdata", rd0.rd_wdata, wdata_of(e));
      chk("d0_count", count0, n - k);
      rd0.rd_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (rd0.rd_ready) k++;
    end
    rd0.rd_ready = 1'b0;
    chk("d0_bound", k, n);
    chk("d0_idle_done", done0, 0);
    chk("d0_idle_cnt", count0, 0);
    chk("d0_idle_valid", rd0.rd_valid, 0);
  endtask

  initial begin
    rd0.rd_ready = 1'b0;
    rd1.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", count0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid", rd0.rd_valid, 0);
    chk("rst_trig", trig0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // cap_en in IDLE is ignored
    cap(32'h0000_0abc);
    chk("idle_cap", count0, 0);

    // FILL capture
    pulse_arm0(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      cap(32'(4 * i));
      if (i == 14) begin
        chk("fill_cnt15", count0, 15);
        chk("fill_nodone", done0, 0);
      end
      if (i == 15) begin
        chk("fill_done", done0, 1);
        chk("fill_cnt16", count0, 16);
        chk("fill_valid", rd0.rd_valid, 1);
      end
    end
    chk("fill_cnt_hold", count0, 16);
    // arm in DRAIN is ignored
    arm0 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0;
    chk("drain_arm_cnt", count0, 16);
    chk("drain_arm_done", done0, 1);
    drain0(32'h0, 16, 1'b0);

    // WRAP, trigger 0x80, POST_TRIG 4, arm mid-capture ignored
    pulse_arm0(1'b1, 32'h80);
    for (int i = 0; i < 38; i++) begin
      if (i == 5) arm0 = 1'b1;
      cap(32'(4 * i));
      arm0 = 1'b0;
      if (i == 5) chk("armed_arm_cnt", count0, 6);
      if (i == 31) chk("wrap_pretrig", trig0, 0);
      if (i == 32) chk("wrap_trig", trig0, 1);
      if (i == 35) chk("wrap_post_nodone", done0, 0);
      if (i == 36) chk("wrap_done", done0, 1);
    end
    chk("wrap_cnt", count0, 16);
    drain0(32'h54, 16, 1'b1);

    // WRAP with POST_TRIG 0 on dut1
    mode = 1'b1;
    trig_pc = 32'h8;
    arm1 = 1'b1;
    @(negedge clk);
    arm1 = 1'b0;
    cap(32'h0);
    cap(32'h4);
    cap(32'h8);
    cap(32'hC);
    chk("pt0_cnt", count1, 3);
    chk("pt0_done", done1, 1);
    chk("pt0_trig", trig1, 1);
    rd1.rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("pt0_valid", rd1.rd_valid, 1);
      chk("pt0_pc", rd1.rd_pc, 4 * k);
      @(negedge clk);
    end
    rd1.rd_ready = 1'b0;
    chk("pt0_idle", done1, 0);
    chk("pt0_empty", rd1.rd_valid, 0);

    // async reset during POST
    pulse_arm0(1'b1, 32'h10);
    for (int i = 0; i < 6; i++) cap(32'(4 * i));
    chk("post_state", trig0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rpost_cnt", count0, 0);
    chk("rpost_trig", trig0, 0);
    chk("rpost_done", done0, 0);
    chk("rpost_valid", rd0.rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // async reset during DRAIN
    pulse_arm0(1'b0, 32'h0);
    for (int i = 0; i < 16; i++) cap(32'(4 * i));
    chk("rdr_pre", done0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdr_cnt", count0, 0);
    chk("rdr_done", done0, 0);
    chk("rdr_valid", rd0.rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // re-arm after reset works normally
    pulse_arm0(1'b0, 32'h0);
    for (int i = 0; i < 16; i++) cap(32'h1000 + 32'(4 * i));
    chk("rearm_cnt", count0, 16);
    drain0(32'h1000, 16, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
